alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 32-bit bitwise logic units (AND/OR/XOR).
- Captures each unit result `s` through a valid/ready handshake, using a 2-entry skid buffer.
- Computes status flags at capture time: zero, negative, popcount.
- Maintains a saturating count of results delivered to the consumer (writeback / flag register).

---
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/alu_result_stage.sv | 106 ++++++++++
 tb/tb_alu_result_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle for alu_result_stage: upstream result in, flagged result out.
// Carries out_parity only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 6
);
    logic [WIDTH-1:0] s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic [PC_W-1:0]  out_popcnt;
`ifdef ALU_RESULT_PARITY_EN
    logic             out_parity;
`endif
    logic             out_valid;
    logic             out_ready;

    modport master (
        output s, in_valid, out_ready,
`ifdef ALU_RESULT_PARITY_EN
        input  out_parity,
`endif
        input  in_ready, out_result, out_zero, out_neg, out_popcnt, out_valid
    );

    modport slave (
        input  s, in_valid, out_ready,
`ifdef ALU_RESULT_PARITY_EN
        output out_parity,
`endif
        output in_ready, out_result, out_zero, out_neg, out_popcnt, out_valid
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage with 2-entry skid buffer, per-entry status flags and
// a saturating delivered-result counter. Define ALU_RESULT_PARITY_EN for out_parity.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int PC_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_stage_if.slave        bus,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         deliv_cnt
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic [PC_W-1:0]  popcnt;
`ifdef ALU_RESULT_PARITY_EN
        logic             parity;
`endif
    } entry_t;

    logic [1:0] state;
    entry_t     head;
    entry_t     skid;
    logic       accept;
    logic       deliver;

    // Flags are computed once, as the value is written into an entry.
    function automatic entry_t make_entry(input logic [WIDTH-1:0] value);
        entry_t e;
        e.result = value;
        e.zero   = ~|value;
        e.neg    = value[WIDTH-1];
        e.popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            e.popcnt = e.popcnt + PC_W'(value[i]);
        end
`ifdef ALU_RESULT_PARITY_EN
        e.parity = ^value;
`endif
        return e;
    endfunction

    assign bus.in_ready   = (state != ST_FULL);
    assign bus.out_valid  = (state != ST_EMPTY);
    assign bus.out_result = head.result;
    assign bus.out_zero   = head.zero;
    assign bus.out_neg    = head.neg;
    assign bus.out_popcnt = head.popcnt;
`ifdef ALU_RESULT_PARITY_EN
    assign bus.out_parity = head.parity;
`endif

    assign accept  = bus.in_valid & bus.in_ready;
    assign deliver = bus.out_valid & bus.out_ready;

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: entries are reset too, because their flags drive outputs directly.
            state     <= ST_EMPTY;
            head      <= '0;
            skid      <= '0;
            deliv_cnt <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head  <= make_entry(bus.s);
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        head <= make_entry(bus.s);
                    end else if (accept) begin
                        skid  <= make_entry(bus.s);
                        state <= ST_FULL;
                    end else if (deliver) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        head  <= skid;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase

            // Clear has priority over a same-edge delivery.
            if (cnt_clr) begin
                deliv_cnt <= '0;
            end else if (deliver && (deliv_cnt != '1)) begin
                deliv_cnt <= deliv_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver queues expected entries, a
// negedge monitor checks the head and the delivered counter against a model.
module tb_alu_result_stage;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int PC_W  = 6;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic [PC_W-1:0]  popcnt;
        logic             parity;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr;
    logic [CNT_W-1:0] deliv_cnt;
    int               n_checks = 0;
    int               n_err = 0;
    int               model_cnt = 0;
    exp_t             exp_q[$];

    alu_result_stage_if #(.WIDTH(WIDTH), .PC_W(PC_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .cnt_clr   (cnt_clr),
        .deliv_cnt (deliv_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [WIDTH-1:0] v);
        exp_t e;
        e.result = v;
        e.zero   = (v == 0);
        e.neg    = v[WIDTH-1];
        e.popcnt = PC_W'($countones(v));
        e.parity = ($countones(v) % 2) == 1;
        return e;
    endfunction

    // One cycle of stimulus, applied just after the rising edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.s         = d;
        bus.out_ready = ordy;
        cnt_clr       = clr;
        if (rst_n && v && bus.in_ready) exp_q.push_back(expect_of(d));
    endtask

    // Monitor: head must match the oldest outstanding entry; pop on delivery.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check("sb_result", 64'(bus.out_result), 64'(exp_q[0].result));
                check("sb_zero",   64'(bus.out_zero),   64'(exp_q[0].zero));
                check("sb_neg",    64'(bus.out_neg),    64'(exp_q[0].neg));
                check("sb_popcnt", 64'(bus.out_popcnt), 64'(exp_q[0].popcnt));
`ifdef ALU_RESULT_PARITY_EN
                check("sb_parity", 64'(bus.out_parity), 64'(exp_q[0].parity));
`endif
                if (rst_n && bus.out_ready) void'(exp_q.pop_front());
            end
        end
        check("deliv_cnt", 64'(deliv_cnt), 64'(model_cnt));
        if (!rst_n || cnt_clr) model_cnt = 0;
        else if (bus.out_valid === 1'b1 && bus.out_ready && model_cnt < (1 << CNT_W) - 1)
            model_cnt++;
    end

    initial begin
        logic [WIDTH-1:0] d;
        bus.in_valid  = 1'b1;
        bus.s         = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        cnt_clr       = 1'b0;

        // Reset with in_valid high: must be ignored.
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_result",    64'(bus.out_result), 64'd0);
        check("rst_zero",      64'(bus.out_zero),  64'd0);
        check("rst_neg",       64'(bus.out_neg),   64'd0);
        check("rst_popcnt",    64'(bus.out_popcnt), 64'd0);
        check("rst_cnt",       64'(deliv_cnt),     64'd0);

        // Single transfer.
        step(1'b1, 32'h8000_0001, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("single_valid",  64'(bus.out_valid),  64'd1);
        check("single_result", 64'(bus.out_result), 64'h8000_0001);
        check("single_neg",    64'(bus.out_neg),    64'd1);
        check("single_zero",   64'(bus.out_zero),   64'd0);
        check("single_popcnt", 64'(bus.out_popcnt), 64'd2);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_cnt",    64'(deliv_cnt),      64'd1);
        check("single_empty",  64'(bus.out_valid),  64'd0);

        // Backpressure into FULL, then drain in order.
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready),   64'd0);
        check("bp_head",     64'(bus.out_result), 64'd0);
        check("bp_zero",     64'(bus.out_zero),   64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_second",   64'(bus.out_result), 64'hFFFF_FFFF);
        check("bp_popcnt",   64'(bus.out_popcnt), 64'd32);
        check("bp_neg",      64'(bus.out_neg),    64'd1);
        check("bp_ready_up", 64'(bus.in_ready),   64'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_cnt",      64'(deliv_cnt),      64'd3);

        // Streaming 1..8 after a counter clear.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, WIDTH'(i), 1'b1, 1'b0);
            @(negedge clk);
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            if (i > 1) check("stream_valid", 64'(bus.out_valid), 64'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("stream_cnt", 64'(deliv_cnt), 64'd8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            d = $urandom;
            if ($urandom_range(0, 9) == 0) d = '0;
            else if ($urandom_range(0, 9) == 0) d = '1;
            step($urandom_range(0, 9) < 6, d, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Counter saturation and clear-wins.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 65535; i++) step(1'b1, $urandom, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("cnt_max", 64'(deliv_cnt), 64'hFFFF);
        step(1'b1, 32'd5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'd6, 1'b1, 1'b0);
        @(negedge clk);
        check("cnt_sat", 64'(deliv_cnt), 64'hFFFF);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("cnt_clr_wins", 64'(deliv_cnt), 64'd0);
        check("cnt_clr_empty", 64'(bus.out_valid), 64'd0);

        // Reset while FULL: buffered entries are discarded.
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_full", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("mid_valid",  64'(bus.out_valid),  64'd0);
        check("mid_ready",  64'(bus.in_ready),   64'd1);
        check("mid_result", 64'(bus.out_result), 64'd0);
        check("mid_cnt",    64'(deliv_cnt),      64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("mid_no_deliver", 64'(deliv_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
